uart_rx_core: RTL

- UART receiver: the receive-side counterpart of the team's 8N1 transmitter/baudrate pair.
- Deserialises an 8N1 line into bytes and presents them on a valid/ready interface.
- Used for loopback and host-to-board traffic on the DE2-115 design, alongside the LFSR/FIFO/Tx path.
- Generates its own 16x oversampling enable from clk_50 and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_core_if.sv | 29 ++
 rtl/uart_rx_tick.sv | 39 +++
 rtl/uart_rx_core.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART constants, receiver state encoding, divisor helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int OVS        = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, integer-truncated; the transmitter uses the same rounding.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_core_if.sv
// ============================================================================
// uart_rx_core_if : serial line in, received byte out over valid/ready
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_core_if;

  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport slave (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, rx_busy
  );

  modport master (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, rx_busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_tick.sv
// ============================================================================
// uart_rx_tick : oversample tick divider with synchronous restart
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_tick #(
  parameter int DIV = 27
) (
  input  logic clk_50,
  input  logic clr,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !restart_i && (cnt_q == LAST);
    cnt_d  = cnt_q + CW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_50 or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core : 8N1 UART receiver, 16x oversampled, framing/overrun flags
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = calc_div(CLK_HZ, BAUD)
) (
  input  logic            clk_50,
  input  logic            clr,
  uart_rx_core_if.slave   bus
);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_core: DIV must be >= 1");
  end

  localparam logic [3:0] SCNT_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SCNT_LAST = 4'(OVS - 1);
  localparam logic [2:0] BCNT_LAST = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic [3:0]           scnt_q, scnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic rx_s;
  logic tick;
  logic tick_restart;

  assign rx_s         = sync_q[1];
  assign tick_restart = (state_q == ST_IDLE);

  // Holding the divider in IDLE phase-aligns every tick to the detected start edge.
  uart_rx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_50    (clk_50),
    .clr       (clr),
    .restart_i (tick_restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        scnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == SCNT_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == SCNT_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == BCNT_LAST) begin
              state_d = ST_STOP;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == SCNT_LAST) begin
            if (rx_s) begin
              state_d = ST_IDLE;
              // A consumer taking the old byte this cycle frees the slot for the new one.
              if (!valid_q || bus.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              state_d = ST_BREAK;
              ferr_d  = 1'b1;
            end
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b11;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], bus.rx};
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.rx_busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire
